// File: rtl/if_id_fetch_stage.sv
// IF stage PC register plus IF/ID pipeline register with RUN/STALL/FLUSH state; IF_ID_PERF_EN adds stall/flush counters.
// Latency: out_Instruction/out_PC_4 follow out_FetchPC by one cycle; redirect/stall take effect on the next edge.
// Backpressure: in_Stall holds PC and IF/ID unchanged; in_Redirect has priority and injects a bubble (NOP, out_Valid=0).
module if_id_fetch_stage #(
    parameter int               NBits    = 32,
    parameter logic [NBits-1:0] RESET_PC = NBits'(32'h0040_0000)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_Stall,
    input  logic             in_Redirect,
    input  logic [NBits-1:0] in_RedirectPC,
    input  logic [NBits-1:0] in_Instruction,
    output logic [NBits-1:0] out_FetchPC,
    output logic [NBits-1:0] out_PC_4,
    output logic [NBits-1:0] out_Instruction,
    output logic             out_Valid,
    output logic [1:0]       out_State
`ifdef IF_ID_PERF_EN
    ,
    output logic [15:0]      out_StallCount,
    output logic [15:0]      out_FlushCount
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [NBits-1:0] instruction;
        logic [NBits-1:0] pc4;
        logic             valid;
    } ifid_t;

    state_t           state;
    state_t           nextState;
    ifid_t            ifid;
    logic [NBits-1:0] fetchPc;
    logic [NBits-1:0] pcPlus4;
    logic [NBits-1:0] redirectAligned;
    logic             unusedRedirectLsbs;

    // Target is forced word-aligned; the two low bits carry no meaning here.
    assign redirectAligned    = {in_RedirectPC[NBits-1:2], 2'b00};
    assign unusedRedirectLsbs = ^in_RedirectPC[1:0];
    assign pcPlus4            = fetchPc + NBits'(4);

    always_comb begin
        nextState = RUN;
        if (in_Redirect) begin
            nextState = FLUSH;
        end else if (in_Stall) begin
            nextState = STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc <= RESET_PC;
        end else if (in_Redirect) begin
            fetchPc <= redirectAligned;
        end else if (!in_Stall) begin
            fetchPc <= pcPlus4;
        end
    end

    // A stall holds whatever occupies IF/ID, including a bubble left by a flush.
    always_ff @(posedge clk) begin
        if (reset || in_Redirect) begin
            ifid <= '0;
        end else if (!in_Stall) begin
            ifid.instruction <= in_Instruction;
            ifid.pc4         <= pcPlus4;
            ifid.valid       <= 1'b1;
        end
    end

    assign out_FetchPC     = fetchPc;
    assign out_PC_4        = ifid.pc4;
    assign out_Instruction = ifid.instruction;
    assign out_Valid       = ifid.valid;
    assign out_State       = state;

`ifdef IF_ID_PERF_EN
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (nextState == STALL && stallCount != 16'hFFFF) begin
                stallCount <= stallCount + 16'd1;
            end
            if (nextState == FLUSH && flushCount != 16'hFFFF) begin
                flushCount <= flushCount + 16'd1;
            end
        end
    end

    assign out_StallCount = stallCount;
    assign out_FlushCount = flushCount;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed + random bench for if_id_fetch_stage with a queue scoreboard fed by a reference model.
module tb_if_id_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, in_Stall, in_Redirect;
    logic [31:0] in_RedirectPC, in_Instruction;
    logic [31:0] out_FetchPC, out_PC_4, out_Instruction;
    logic        out_Valid;
    logic [1:0]  out_State;

    logic        wReset;
    logic [31:0] wFetchPC, wPC4, wInstr;
    logic        wValid;
    logic [1:0]  wState;
`ifdef IF_ID_PERF_EN
    logic [15:0] stallCount, flushCount, wStallCount, wFlushCount;
`endif

    int total = 0;
    int bad   = 0;
    bit memMode = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ins;
        logic        v;
        logic [1:0]  st;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mPc, mPc4, mIns;
    logic        mV;
    logic [1:0]  mSt;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a, input bit mode);
        return mode ? {a[15:0], 16'h1235} : 32'h2008_0005;
    endfunction

    assign in_Instruction = memf(out_FetchPC, memMode);

    if_id_fetch_stage dut (
        .clk(clk), .reset(reset), .in_Stall(in_Stall), .in_Redirect(in_Redirect),
        .in_RedirectPC(in_RedirectPC), .in_Instruction(in_Instruction),
        .out_FetchPC(out_FetchPC), .out_PC_4(out_PC_4), .out_Instruction(out_Instruction),
        .out_Valid(out_Valid), .out_State(out_State)
`ifdef IF_ID_PERF_EN
        , .out_StallCount(stallCount), .out_FlushCount(flushCount)
`endif
    );

    if_id_fetch_stage #(.NBits(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .reset(wReset), .in_Stall(1'b0), .in_Redirect(1'b0),
        .in_RedirectPC(32'h0), .in_Instruction(32'h2008_0005),
        .out_FetchPC(wFetchPC), .out_PC_4(wPC4), .out_Instruction(wInstr),
        .out_Valid(wValid), .out_State(wState)
`ifdef IF_ID_PERF_EN
        , .out_StallCount(wStallCount), .out_FlushCount(wFlushCount)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model the edge, queue the expectation, clock the DUT, compare.
    task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc);
        exp_t e;
        if (rst) begin
            mPc = 32'h0040_0000; mPc4 = 0; mIns = 0; mV = 0; mSt = 2'd0;
        end else if (rd) begin
            mPc = {rpc[31:2], 2'b00}; mPc4 = 0; mIns = 0; mV = 0; mSt = 2'd2;
        end else if (st) begin
            mSt = 2'd1;
        end else begin
            mIns = memf(mPc, memMode); mPc4 = mPc + 32'd4; mV = 1; mPc = mPc + 32'd4; mSt = 2'd0;
        end
        e.pc = mPc; e.pc4 = mPc4; e.ins = mIns; e.v = mV; e.st = mSt;
        sb.push_back(e);
        reset = rst; in_Stall = st; in_Redirect = rd; in_RedirectPC = rpc;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("fetchPC", out_FetchPC, e.pc);
        chk("pc4", out_PC_4, e.pc4);
        chk("instr", out_Instruction, e.ins);
        chk("valid", {31'b0, out_Valid}, {31'b0, e.v});
        chk("state", {30'b0, out_State}, {30'b0, e.st});
    endtask

    initial begin
        reset = 1; in_Stall = 0; in_Redirect = 0; in_RedirectPC = 0; wReset = 1;
        mPc = 0; mPc4 = 0; mIns = 0; mV = 0; mSt = 0;

        // Reset overrides stall and redirect.
        step(1, 1, 1, 32'h1234_5678);
        step(1, 0, 0, 0);
        chk("rst_pc", out_FetchPC, 32'h0040_0000);
        chk("rst_valid", {31'b0, out_Valid}, 32'd0);

        // Free run with constant memory data.
        step(0, 0, 0, 0);
        chk("run1_pc", out_FetchPC, 32'h0040_0004);
        chk("run1_pc4", out_PC_4, 32'h0040_0004);
        chk("run1_ins", out_Instruction, 32'h2008_0005);
        chk("run1_valid", {31'b0, out_Valid}, 32'd1);
        step(0, 0, 0, 0);
        chk("run2_pc", out_FetchPC, 32'h0040_0008);

        // Three-cycle stall at 0x00400008.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk("stall_pc", out_FetchPC, 32'h0040_0008);
            chk("stall_pc4", out_PC_4, 32'h0040_0008);
            chk("stall_state", {30'b0, out_State}, 32'd1);
        end
        step(0, 0, 0, 0);
        chk("resume_pc", out_FetchPC, 32'h0040_000C);
        chk("resume_state", {30'b0, out_State}, 32'd0);

        memMode = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Redirect to a misaligned target.
        step(0, 0, 1, 32'h0040_0103);
        chk("redir_pc", out_FetchPC, 32'h0040_0100);
        chk("redir_ins", out_Instruction, 32'h0);
        chk("redir_state", {30'b0, out_State}, 32'd2);
        step(0, 0, 0, 0);
        chk("postredir_valid", {31'b0, out_Valid}, 32'd1);
        chk("postredir_pc4", out_PC_4, 32'h0040_0104);

        // Redirect with stall: stall dropped, then stall holds the bubble.
        step(0, 1, 1, 32'h0040_0200);
        chk("rs_state", {30'b0, out_State}, 32'd2);
        chk("rs_pc", out_FetchPC, 32'h0040_0200);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("bubble_valid", {31'b0, out_Valid}, 32'd0);
        chk("bubble_state", {30'b0, out_State}, 32'd1);
        step(0, 0, 0, 0);
        chk("bubble_exit_pc4", out_PC_4, 32'h0040_0204);

        // Back-to-back redirects stay in FLUSH.
        step(0, 0, 1, 32'h0000_1000);
        step(0, 0, 1, 32'h0000_2002);
        chk("b2b_state", {30'b0, out_State}, 32'd2);
        step(0, 0, 0, 0);

        // Reset mid-stall and mid-flush.
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rststall_pc", out_FetchPC, 32'h0040_0000);
        step(0, 0, 1, 32'h0000_3000);
        step(1, 0, 1, 32'h0000_4000);
        chk("rstflush_state", {30'b0, out_State}, 32'd0);
        step(0, 0, 0, 0);
        chk("first_after_rst", {31'b0, out_Valid}, 32'd1);

        // Random mix against the model.
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            step(0, r < 4, r == 0 || r == 9, $urandom);
        end

        // PC wrap instance.
        @(posedge clk); #1;
        chk("wrap_rst_pc", wFetchPC, 32'hFFFF_FFFC);
        wReset = 0;
        @(posedge clk); #1;
        chk("wrap_pc", wFetchPC, 32'h0);
        chk("wrap_pc4", wPC4, 32'h0);
        chk("wrap_valid", {31'b0, wValid}, 32'd1);

`ifdef IF_ID_PERF_EN
        step(1, 0, 0, 0);
        chk("perf_rst", {16'b0, stallCount}, 32'd0);
        step(0, 0, 1, 32'h0);
        chk("perf_flush1", {16'b0, flushCount}, 32'd1);
        reset = 0; in_Redirect = 0; in_Stall = 1;
        repeat (70000) @(posedge clk);
        #1;
        chk("perf_sat", {16'b0, stallCount}, 32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("perf_hold", {16'b0, stallCount}, 32'h0000_FFFF);
        reset = 1;
        @(posedge clk); #1;
        chk("perf_clr", {16'b0, stallCount}, 32'd0);
        chk("perf_fclr", {16'b0, flushCount}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
IF_ID_FETCH_STAGE -- requirements
Module: if_id_fetch_stage

Interface
REQ-001 The block SHALL have parameter NBits, default 32, meaning the datapath width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the PC value after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_Stall, input, 1 bit: load-use hazard hold request from decode.
REQ-006 The block SHALL have port in_Redirect, input, 1 bit: taken branch/jump resolved in execute.
REQ-007 The block SHALL have port in_RedirectPC, input, NBits: redirect target address.
REQ-008 The block SHALL have port in_Instruction, input, NBits: combinational program-memory read data for out_FetchPC.
REQ-009 The block SHALL have port out_FetchPC, output, NBits: current fetch address to program memory.
REQ-010 The block SHALL have port out_PC_4, output, NBits: registered fetch address + 4 of the instruction in IF/ID.
REQ-011 The block SHALL have port out_Instruction, output, NBits: registered instruction fed to decode / ID_EX register.
REQ-012 The block SHALL have port out_Valid, output, 1 bit: high when out_Instruction is a real, non-bubble instruction.
REQ-013 The block SHALL have port out_State, output, 2 bits: FSM state, encoded RUN=2'd0, STALL=2'd1, FLUSH=2'd2.

Function
REQ-014 The PC register SHALL load, in priority order: RESET_PC on reset; {in_RedirectPC[NBits-1:2],2'b00} on in_Redirect; its own value on in_Stall; PC+4 otherwise.
REQ-015 PC+4 SHALL wrap modulo 2^NBits with no flag; in_RedirectPC[1:0] SHALL be ignored.
REQ-016 The IF/ID register SHALL load, in priority order: Instruction=0, PC_4=0, Valid=0 on reset; Instruction=0 (NOP), PC_4=0, Valid=0 on in_Redirect; its own value on in_Stall; in_Instruction, PC+4, Valid=1 otherwise.
REQ-017 Latency from out_FetchPC presentation to the matching out_Instruction SHALL be exactly one cycle when neither stall nor redirect is asserted.
REQ-018 The FSM next state SHALL be: FLUSH if in_Redirect; else STALL if in_Stall; else RUN, regardless of current state.
REQ-019 In FLUSH, out_Valid SHALL be 0; the FSM SHALL leave FLUSH after one cycle unless in_Redirect is asserted again.
REQ-020 Simultaneous in_Redirect and in_Stall SHALL behave as in_Redirect alone: the stall request is dropped.
REQ-021 A stall while a bubble occupies IF/ID SHALL hold the bubble, with out_Valid remaining 0.
REQ-022 A stall SHALL be held for any number of consecutive cycles with no change to any output.

Reset
REQ-023 With reset high at a clk edge, outputs SHALL become: out_FetchPC=RESET_PC, out_PC_4=0, out_Instruction=0, out_Valid=0, out_State=RUN; reset SHALL override in_Stall and in_Redirect.
REQ-024 Reset asserted mid-stall or mid-flush SHALL fully restore the REQ-023 values in one cycle.
REQ-025 The first valid instruction SHALL appear one cycle after reset deasserts.

Configuration
REQ-026 Macro IF_ID_PERF_EN SHALL control the performance counters.
REQ-027 With IF_ID_PERF_EN defined, the block SHALL add outputs out_StallCount [15:0], counting cycles with next state STALL, and out_FlushCount [15:0], counting cycles with next state FLUSH; both SHALL saturate at 16'hFFFF and clear on reset.
REQ-028 Without IF_ID_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset then 3 free-running cycles, memory returning 32'h2008_0005 -> out_FetchPC sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; out_Valid=1 from the second cycle; out_PC_4 of the first instruction=0x00400004.
REQ-030 in_Stall high for 3 cycles at PC 0x00400008 -> out_FetchPC, out_Instruction and out_PC_4 frozen; out_State=STALL for those cycles; fetch resumes at 0x0040000C.
REQ-031 in_Redirect with in_RedirectPC=0x00400103 -> next cycle out_FetchPC=0x00400100, out_Instruction=0, out_Valid=0, out_State=FLUSH; following cycle out_Valid=1, out_State=RUN.
REQ-032 in_Redirect and in_Stall asserted together -> behaves exactly as REQ-031; after the flush, out_State returns to RUN unless in_Stall is still high.
REQ-033 With RESET_PC=32'hFFFF_FFFC and one free cycle -> out_FetchPC wraps to 0; reset pulsed during a stall -> the REQ-023 values appear on the next edge.
REQ-034 With IF_ID_PERF_EN defined, 70000 stall cycles -> out_StallCount=16'hFFFF and holds; after reset -> 0.
